// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the data-memory port-2 read path:
//               address/data widths, the port-1 to port-2 address offset,
//               common typedefs and the streamer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int ADDR_W       = 20;
  localparam int DATA_W       = 16;
  // Port 2 sees the same array as port 1, shifted down by this many words.
  localparam int PORT2_OFFSET = 76;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word16_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } streamer_state_t;

  // Converts a port-1 address into the equivalent port-2 address.
  function automatic addr_t port1_to_port2(input addr_t port1_addr);
    return port1_addr - addr_t'(PORT2_OFFSET);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo
// Description : Synchronous single-clock FIFO with first-word-fall-through
//               output (dout always shows the head entry).
// Ports       : clk, rst (async, active-low)
//               push/din   - write one entry
//               pop        - discard the head entry
//               dout       - head entry
//               count      - number of stored entries (0..DEPTH)
//               empty/full - status flags
// Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8    // power of two
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Guard against misuse; the streamer's credit scheme never exercises these.
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop  & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + c_AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == (c_AW+1)'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/mem_port2_streamer.sv
`default_nettype none
// ============================================================================
// Module      : mem_port2_streamer
// Description : Walks a contiguous address range through data-memory read
//               port 2, absorbs the fixed read latency and delivers the words
//               as a valid/ready stream through a small output FIFO.
// Ports       : clk, rst (async, active-low)
//               start, base_addr, length - run command (sampled in IDLE)
//               address2, qb             - data memory port 2
//               out_data, out_valid, out_ready - output stream
//               busy, done               - run status
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port2_streamer #(
  parameter int ADDR_W     = mem_pkg::ADDR_W,
  parameter int DATA_W     = mem_pkg::DATA_W,
  parameter int FIFO_DEPTH = 8,   // power of two, >= READ_LAT+2
  parameter int READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] address2,
  input  logic [DATA_W-1:0] qb,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  import mem_pkg::*;

  // One stage covers the address2 register, READ_LAT stages the memory itself.
  localparam int c_PIPE_D = READ_LAT + 1;
  localparam int c_CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int c_SUM_W  = $clog2(FIFO_DEPTH + c_PIPE_D + 1) + 1;

  streamer_state_t r_state;
  streamer_state_t w_state_nxt;

  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_len;
  logic [ADDR_W-1:0]   r_issue_cnt;
  logic [ADDR_W-1:0]   r_pop_cnt;
  logic [ADDR_W-1:0]   r_addr2;
  logic [ADDR_W-1:0]   w_issue_cnt_inc;
  logic [c_PIPE_D-1:0] r_pipe;
  logic                r_zero_done;

  logic                w_accept;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_last_popped;
  logic                w_credit;
  logic [c_SUM_W-1:0]  w_inflight;

  logic [DATA_W-1:0]   w_fifo_dout;
  logic [c_CNT_W-1:0]  w_fifo_count;
  logic                w_fifo_empty;
  logic                w_fifo_full;

  // A start coinciding with the zero-length done pulse is dropped.
  assign w_accept        = (r_state == IDLE) && start && !r_zero_done;
  assign w_issue_cnt_inc = r_issue_cnt + ADDR_W'(1);
  assign w_last_popped   = (r_pop_cnt == r_len);
  assign w_push          = r_pipe[c_PIPE_D-1];
  assign w_pop           = out_valid & out_ready;

  // Reads in flight = set bits in the latency pipe.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < c_PIPE_D; i++) begin
      w_inflight = w_inflight + c_SUM_W'(r_pipe[i]);
    end
  end

  // Only issue when the word is guaranteed a FIFO slot on arrival.
  assign w_credit = (c_SUM_W'(w_fifo_count) + w_inflight) < c_SUM_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept && (length != '0)) w_state_nxt = RUN;
      RUN:     if (w_issue && (w_issue_cnt_inc == r_len)) w_state_nxt = DRAIN;
      DRAIN:   if (w_last_popped) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_issue = (r_state == RUN) && (r_issue_cnt != r_len) && w_credit && !w_fifo_full;
    busy    = (r_state != IDLE);
    done    = ((r_state == DRAIN) && w_last_popped) || r_zero_done;
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base      <= '0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_pop_cnt   <= '0;
      r_addr2     <= '0;
      r_pipe      <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= w_accept && (length == '0);
      r_pipe      <= {r_pipe[c_PIPE_D-2:0], w_issue};
      if (w_accept) begin
        r_base      <= base_addr;
        r_len       <= length;
        r_issue_cnt <= '0;
        r_pop_cnt   <= '0;
      end else begin
        if (w_issue) begin
          // Natural ADDR_W overflow gives the required address wrap.
          r_addr2     <= r_base + r_issue_cnt;
          r_issue_cnt <= w_issue_cnt_inc;
        end
        if (w_pop) begin
          r_pop_cnt <= r_pop_cnt + ADDR_W'(1);
        end
      end
    end
  end

  assign address2 = r_addr2;

  stream_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (qb),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .count (w_fifo_count),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  assign out_data  = w_fifo_dout;
  assign out_valid = ~w_fifo_empty;

endmodule
`default_nettype wire
